// File: rtl/rv_mem_pkg.sv
// Shared encodings for the memory stage: Funct3 widths,
// ResultSrc selects and the bus-handshake FSM states.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/load_align.sv
// Picks the addressed lane of a read word and
// sign- or zero-extends it to 32 bits.
module load_align
  import rv_mem_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    unique case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// M stage: drives the data bus, stalls on wait states,
// aligns load data and registers the M/W bundle.
module memory_stage
  import rv_mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ValidM_i,
  input  logic        RegWriteM_i,
  input  logic [1:0]  ResultSrcM_i,
  input  logic        MemWriteM_i,
  input  logic [2:0]  Funct3M_i,
  input  logic [4:0]  RdM_i,
  input  logic [31:0] ALUResultM_i,
  input  logic [31:0] WriteDataM_i,
  input  logic [31:0] PCPlus4M_i,
  output logic        DReq_o,
  output logic        DWe_o,
  output logic [31:0] DAddr_o,
  output logic [31:0] DWData_o,
  output logic [3:0]  DBe_o,
  input  logic        DAck_i,
  input  logic [31:0] DRData_i,
  input  logic        DErr_i,
  output logic        RegWriteW_o,
  output logic [1:0]  ResultSrcW_o,
  output logic [4:0]  RdW_o,
  output logic [31:0] ALUResultW_o,
  output logic [31:0] ReadDataW_o,
  output logic [31:0] PCPlus4W_o,
  output logic        StallM_o,
  output logic        ExcW_o
);

  mem_state_e  state;
  logic        is_load;
  logic        is_store;
  logic        misal_raw;
  logic        misal;
  logic        req;
  logic        done;
  logic        exc;
  logic [1:0]  lane;
  logic [31:0] load_data;

  assign lane     = ALUResultM_i[1:0];
  assign is_load  = ValidM_i & (ResultSrcM_i == RES_MEM);
  assign is_store = ValidM_i & MemWriteM_i;

  always_comb begin
    unique case (Funct3M_i[1:0])
      2'b01:   misal_raw = lane[0];
      2'b10:   misal_raw = |lane;
      default: misal_raw = 1'b0;
    endcase
  end

  assign misal    = (is_load | is_store) & misal_raw;
  assign req      = (is_load | is_store) & ~misal;
  assign done     = req & DAck_i;
  assign exc      = misal | (done & DErr_i);
  assign DReq_o   = req;
  assign StallM_o = req & ~DAck_i;
  assign DWe_o    = is_store & ~misal;
  assign DAddr_o  = {ALUResultM_i[31:2], 2'b00};

  always_comb begin
    DBe_o    = 4'b1111;
    DWData_o = WriteDataM_i;
    if (is_store) begin
      unique case (Funct3M_i[1:0])
        2'b00: begin
          DBe_o    = 4'b0001 << lane;
          DWData_o = {4{WriteDataM_i[7:0]}};
        end
        2'b01: begin
          DBe_o    = 4'b0011 << lane;
          DWData_o = {2{WriteDataM_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  load_align u_align (
    .addr   (lane),
    .funct3 (Funct3M_i),
    .rdata  (DRData_i),
    .data   (load_data)
  );

  // Ack without an outstanding request never moves the FSM.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else if (!req) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    state <= DAck_i ? IDLE : WAIT;
        default: state <= DAck_i ? IDLE : WAIT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      RegWriteW_o  <= 1'b0;
      ExcW_o       <= 1'b0;
      ResultSrcW_o <= 2'b00;
      RdW_o        <= 5'd0;
      ALUResultW_o <= 32'd0;
      ReadDataW_o  <= 32'd0;
      PCPlus4W_o   <= 32'd0;
    end else if (StallM_o) begin
      RegWriteW_o <= 1'b0;
      ExcW_o      <= 1'b0;
    end else begin
      RegWriteW_o  <= RegWriteM_i & ValidM_i & (|RdM_i) & ~exc;
      ExcW_o       <= exc;
      ResultSrcW_o <= ResultSrcM_i;
      RdW_o        <= RdM_i;
      ALUResultW_o <= ALUResultM_i;
      ReadDataW_o  <= load_data;
      PCPlus4W_o   <= PCPlus4M_i;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: loads, stores,
// wait states, misalignment, bus errors and reset.
module tb_memory_stage;
  import rv_mem_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ValidM_i, RegWriteM_i, MemWriteM_i;
  logic [1:0]  ResultSrcM_i;
  logic [2:0]  Funct3M_i;
  logic [4:0]  RdM_i;
  logic [31:0] ALUResultM_i, WriteDataM_i, PCPlus4M_i;
  logic        DReq_o, DWe_o;
  logic [31:0] DAddr_o, DWData_o;
  logic [3:0]  DBe_o;
  logic        DAck_i, DErr_i;
  logic [31:0] DRData_i;
  logic        RegWriteW_o;
  logic [1:0]  ResultSrcW_o;
  logic [4:0]  RdW_o;
  logic [31:0] ALUResultW_o, ReadDataW_o, PCPlus4W_o;
  logic        StallM_o, ExcW_o;

  int checks = 0;
  int fails  = 0;

  always #5 clk_i = ~clk_i;

  memory_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ValidM_i(ValidM_i), .RegWriteM_i(RegWriteM_i),
    .ResultSrcM_i(ResultSrcM_i), .MemWriteM_i(MemWriteM_i),
    .Funct3M_i(Funct3M_i), .RdM_i(RdM_i),
    .ALUResultM_i(ALUResultM_i), .WriteDataM_i(WriteDataM_i),
    .PCPlus4M_i(PCPlus4M_i),
    .DReq_o(DReq_o), .DWe_o(DWe_o), .DAddr_o(DAddr_o),
    .DWData_o(DWData_o), .DBe_o(DBe_o),
    .DAck_i(DAck_i), .DRData_i(DRData_i), .DErr_i(DErr_i),
    .RegWriteW_o(RegWriteW_o), .ResultSrcW_o(ResultSrcW_o),
    .RdW_o(RdW_o), .ALUResultW_o(ALUResultW_o),
    .ReadDataW_o(ReadDataW_o), .PCPlus4W_o(PCPlus4W_o),
    .StallM_o(StallM_o), .ExcW_o(ExcW_o)
  );

  task automatic idle_in();
    ValidM_i = 0; RegWriteM_i = 0; MemWriteM_i = 0;
    ResultSrcM_i = RES_ALU; Funct3M_i = 3'd0; RdM_i = 5'd0;
    ALUResultM_i = 0; WriteDataM_i = 0; PCPlus4M_i = 0;
    DAck_i = 0; DErr_i = 0; DRData_i = 0;
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a,
                      input logic [4:0] rd);
    ValidM_i = 1; RegWriteM_i = 1; MemWriteM_i = 0;
    ResultSrcM_i = RES_MEM; Funct3M_i = f3; RdM_i = rd;
    ALUResultM_i = a; PCPlus4M_i = 32'h1004;
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    ValidM_i = 1; RegWriteM_i = 0; MemWriteM_i = 1;
    ResultSrcM_i = RES_ALU; Funct3M_i = f3; RdM_i = 5'd0;
    ALUResultM_i = a; WriteDataM_i = d;
  endtask

  task automatic test_reset();
    idle_in();
    rst_ni = 0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({RegWriteW_o, ExcW_o, RdW_o, ReadDataW_o, ALUResultW_o} !== '0) begin
      fails++;
      $display("FAIL reset_w: W regs not zero rw=%b exc=%b rd=%0d",
               RegWriteW_o, ExcW_o, RdW_o);
    end
    checks++;
    if (DReq_o !== 1'b0 || StallM_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_bus: dreq=%b stall=%b want 0 0", DReq_o, StallM_o);
    end
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic test_lb();
    int stalls = 0;
    @(negedge clk_i);
    load(F3_B, 32'h103, 5'd7);
    DRData_i = 32'h80FF_1234; DAck_i = 1;
    #1;
    if (StallM_o) stalls++;
    checks++;
    if (DReq_o !== 1'b1 || DBe_o !== 4'b1111 || DAddr_o !== 32'h100) begin
      fails++;
      $display("FAIL lb_bus: req=%b be=%b addr=%h want 1 1111 100",
               DReq_o, DBe_o, DAddr_o);
    end
    @(posedge clk_i); #1;
    if (StallM_o) stalls++;
    checks++;
    if (ReadDataW_o !== 32'hFFFF_FF80 || RegWriteW_o !== 1'b1 ||
        RdW_o !== 5'd7 || ExcW_o !== 1'b0) begin
      fails++;
      $display("FAIL lb_w: data=%h rw=%b rd=%0d exc=%b want ffffff80 1 7 0",
               ReadDataW_o, RegWriteW_o, RdW_o, ExcW_o);
    end
    checks++;
    if (stalls != 0) begin
      fails++;
      $display("FAIL lb_stall: stall seen %0d cycles want 0", stalls);
    end
  endtask

  task automatic test_sh_wait();
    int stalls = 0;
    int bubbles = 0;
    int held = 1;
    @(negedge clk_i);
    idle_in();
    store(F3_H, 32'h202, 32'h0000_BEEF);
    #1;
    checks++;
    if (DBe_o !== 4'b1100 || DWData_o !== 32'hBEEF_BEEF ||
        DAddr_o !== 32'h200 || DWe_o !== 1'b1) begin
      fails++;
      $display("FAIL sh_bus: be=%b wd=%h addr=%h we=%b want 1100 beefbeef 200 1",
               DBe_o, DWData_o, DAddr_o, DWe_o);
    end
    for (int i = 0; i < 3; i++) begin
      if (StallM_o) stalls++;
      if (DAddr_o !== 32'h200 || DBe_o !== 4'b1100 || DReq_o !== 1'b1) held = 0;
      @(posedge clk_i); #1;
      if (RegWriteW_o === 1'b0 && ExcW_o === 1'b0) bubbles++;
      @(negedge clk_i);
    end
    checks++;
    if (dut.state !== WAIT) begin
      fails++;
      $display("FAIL sh_wait_state: state=%b want WAIT", dut.state);
    end
    DAck_i = 1;
    #1;
    if (StallM_o) stalls++;
    checks++;
    if (stalls != 3 || bubbles != 3 || held != 1) begin
      fails++;
      $display("FAIL sh_stall: stalls=%0d bubbles=%0d held=%0d want 3 3 1",
               stalls, bubbles, held);
    end
    @(posedge clk_i); #1;
    checks++;
    if (dut.state !== IDLE || RegWriteW_o !== 1'b0 || ExcW_o !== 1'b0) begin
      fails++;
      $display("FAIL sh_done: state=%b rw=%b exc=%b want IDLE 0 0",
               dut.state, RegWriteW_o, ExcW_o);
    end
  endtask

  task automatic test_sb_lanes();
    @(negedge clk_i);
    idle_in();
    store(F3_B, 32'h101, 32'h1234_56A5);
    DAck_i = 1;
    #1;
    checks++;
    if (DBe_o !== 4'b0010 || DWData_o !== 32'hA5A5_A5A5 || StallM_o !== 1'b0) begin
      fails++;
      $display("FAIL sb_bus: be=%b wd=%h stall=%b want 0010 a5a5a5a5 0",
               DBe_o, DWData_o, StallM_o);
    end
    @(negedge clk_i);
    store(F3_W, 32'h10C, 32'hCAFE_F00D);
    #1;
    checks++;
    if (DBe_o !== 4'b1111 || DWData_o !== 32'hCAFE_F00D || DAddr_o !== 32'h10C) begin
      fails++;
      $display("FAIL sw_bus: be=%b wd=%h addr=%h want 1111 cafef00d 10c",
               DBe_o, DWData_o, DAddr_o);
    end
  endtask

  task automatic test_loads();
    @(negedge clk_i);
    idle_in();
    load(F3_HU, 32'h102, 5'd3);
    DRData_i = 32'h80FF_1234; DAck_i = 1;
    @(posedge clk_i); #1;
    checks++;
    if (ReadDataW_o !== 32'h0000_80FF || RegWriteW_o !== 1'b1) begin
      fails++;
      $display("FAIL lhu_data: data=%h rw=%b want 000080ff 1",
               ReadDataW_o, RegWriteW_o);
    end
    @(negedge clk_i);
    load(F3_H, 32'h102, 5'd3);
    @(posedge clk_i); #1;
    checks++;
    if (ReadDataW_o !== 32'hFFFF_80FF) begin
      fails++;
      $display("FAIL lh_data: data=%h want ffff80ff", ReadDataW_o);
    end
    @(negedge clk_i);
    load(F3_BU, 32'h101, 5'd0);
    @(posedge clk_i); #1;
    checks++;
    if (ReadDataW_o !== 32'h0000_0012 || RegWriteW_o !== 1'b0) begin
      fails++;
      $display("FAIL lbu_x0: data=%h rw=%b want 00000012 0",
               ReadDataW_o, RegWriteW_o);
    end
    @(negedge clk_i);
    load(F3_W, 32'h104, 5'd9);
    DRData_i = 32'hDEAD_BEEF;
    @(posedge clk_i); #1;
    checks++;
    if (ReadDataW_o !== 32'hDEAD_BEEF || RegWriteW_o !== 1'b1 ||
        PCPlus4W_o !== 32'h1004) begin
      fails++;
      $display("FAIL lw_data: data=%h rw=%b pc4=%h want deadbeef 1 1004",
               ReadDataW_o, RegWriteW_o, PCPlus4W_o);
    end
  endtask

  task automatic test_misalign();
    @(negedge clk_i);
    idle_in();
    load(F3_W, 32'h105, 5'd4);
    DAck_i = 1;
    #1;
    checks++;
    if (DReq_o !== 1'b0 || StallM_o !== 1'b0) begin
      fails++;
      $display("FAIL mis_req: dreq=%b stall=%b want 0 0", DReq_o, StallM_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (ExcW_o !== 1'b1 || RegWriteW_o !== 1'b0) begin
      fails++;
      $display("FAIL mis_w: exc=%b rw=%b want 1 0", ExcW_o, RegWriteW_o);
    end
    @(negedge clk_i);
    store(F3_H, 32'h203, 32'h1);
    #1;
    checks++;
    if (DReq_o !== 1'b0 || DWe_o !== 1'b0) begin
      fails++;
      $display("FAIL mis_sh_req: dreq=%b we=%b want 0 0", DReq_o, DWe_o);
    end
  endtask

  task automatic test_bus_err();
    @(negedge clk_i);
    idle_in();
    load(F3_HU, 32'h300, 5'd6);
    DRData_i = 32'h1111_2222; DAck_i = 1; DErr_i = 1;
    @(posedge clk_i); #1;
    checks++;
    if (ExcW_o !== 1'b1 || RegWriteW_o !== 1'b0 || dut.state !== IDLE) begin
      fails++;
      $display("FAIL berr: exc=%b rw=%b state=%b want 1 0 IDLE",
               ExcW_o, RegWriteW_o, dut.state);
    end
    @(negedge clk_i);
    idle_in();
    ValidM_i = 1; RegWriteM_i = 1; RdM_i = 5'd2; DAck_i = 1;
    #1;
    checks++;
    if (DReq_o !== 1'b0 || StallM_o !== 1'b0) begin
      fails++;
      $display("FAIL alu_noreq: dreq=%b stall=%b want 0 0", DReq_o, StallM_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (RegWriteW_o !== 1'b1 || ExcW_o !== 1'b0) begin
      fails++;
      $display("FAIL alu_spurious: rw=%b exc=%b want 1 0", RegWriteW_o, ExcW_o);
    end
  endtask

  task automatic test_reset_wait();
    @(negedge clk_i);
    idle_in();
    load(F3_W, 32'h400, 5'd8);
    @(posedge clk_i); #1;
    checks++;
    if (dut.state !== WAIT || StallM_o !== 1'b1) begin
      fails++;
      $display("FAIL rw_enter: state=%b stall=%b want WAIT 1",
               dut.state, StallM_o);
    end
    @(negedge clk_i);
    rst_ni = 0;
    ValidM_i = 0;
    @(posedge clk_i); #1;
    checks++;
    if (dut.state !== IDLE || DReq_o !== 1'b0 || StallM_o !== 1'b0 ||
        RegWriteW_o !== 1'b0 || ExcW_o !== 1'b0 || ReadDataW_o !== '0 ||
        PCPlus4W_o !== '0) begin
      fails++;
      $display("FAIL rw_reset: state=%b dreq=%b rw=%b exc=%b pc4=%h want all 0",
               dut.state, DReq_o, RegWriteW_o, ExcW_o, PCPlus4W_o);
    end
    @(negedge clk_i);
    rst_ni = 1;
    DAck_i = 1;
    DRData_i = 32'h5555_5555;
    #1;
    checks++;
    if (DReq_o !== 1'b0 || StallM_o !== 1'b0) begin
      fails++;
      $display("FAIL rw_late_req: dreq=%b stall=%b want 0 0", DReq_o, StallM_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (dut.state !== IDLE || RegWriteW_o !== 1'b0 || ExcW_o !== 1'b0) begin
      fails++;
      $display("FAIL rw_late_ack: state=%b rw=%b exc=%b want IDLE 0 0",
               dut.state, RegWriteW_o, ExcW_o);
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh_wait();
    test_sb_lanes();
    test_loads();
    test_misalign();
    test_bus_err();
    test_reset_wait();
    @(negedge clk_i);
    idle_in();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_ni, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have inputs ValidM_i (1), RegWriteM_i (1), ResultSrcM_i (2), MemWriteM_i (1), Funct3M_i (3), RdM_i (5), ALUResultM_i (32), WriteDataM_i (32), PCPlus4M_i (32): M-stage instruction fields.
REQ-004 SHALL have data-bus outputs DReq_o (1), DWe_o (1), DAddr_o (32, word-aligned), DWData_o (32), DBe_o (4).
REQ-005 SHALL have data-bus inputs DAck_i (1, completes request; read data valid same cycle), DRData_i (32), DErr_i (1, bus error, qualified by DAck_i).
REQ-006 SHALL have W-stage outputs RegWriteW_o (1), ResultSrcW_o (2), RdW_o (5), ALUResultW_o (32), ReadDataW_o (32), PCPlus4W_o (32), all registered.
REQ-007 SHALL have StallM_o (1, freeze F/D/E/M registers) and ExcW_o (1, registered exception flag: misalign or bus error).

Function
REQ-008 SHALL treat an instruction as load when ValidM_i=1 and ResultSrcM_i=01, and as store when ValidM_i=1 and MemWriteM_i=1.
REQ-009 SHALL flag misalignment: halfword (Funct3M_i[1:0]=01) with ALUResultM_i[0]=1; word (10) with ALUResultM_i[1:0]!=00.
REQ-010 SHALL implement FSM IDLE/WAIT; IDLE -> WAIT when an aligned load/store is present and DAck_i=0; WAIT -> IDLE on DAck_i=1.
REQ-011 SHALL assert DReq_o combinationally in IDLE and in WAIT for an aligned load/store; zero-wait memory (DAck_i=1 same cycle) completes in one cycle without entering WAIT.
REQ-012 SHALL hold DAddr_o={ALUResultM_i[31:2],2'b00}, DWe_o, DBe_o, DWData_o constant while DReq_o=1 and DAck_i=0.
REQ-013 SHALL drive StallM_o = DReq_o & ~DAck_i.
REQ-014 SHALL generate stores: SB DBe_o=0001<<addr[1:0], DWData_o=byte replicated x4; SH DBe_o=0011<<addr[1:0], halfword replicated x2; SW DBe_o=1111.
REQ-015 SHALL extract loads: LB/LH sign-extend, LBU (100)/LHU (101) zero-extend, LW (010) pass through, lane chosen by addr[1:0]; DBe_o=1111 for all loads.
REQ-016 SHALL never assert DReq_o for a misaligned access or a non-memory instruction.
REQ-017 SHALL, on each cycle StallM_o=0, load the M/W register from M inputs and extracted load data; W register updates one cycle after completion (latency 1).
REQ-018 SHALL, on cycles with StallM_o=1, load a bubble into W (RegWriteW_o=0, ExcW_o=0; other fields don't-care).
REQ-019 SHALL, on misalign or on DAck_i&DErr_i, set RegWriteW_o=0 and ExcW_o=1 for that instruction's W slot.
REQ-020 SHALL force RegWriteW_o=0 when ValidM_i=0 or RdM_i=0.
REQ-021 SHALL ignore DAck_i when DReq_o=0 (spurious ack: no state change).

Reset
REQ-022 SHALL, while rst_ni=0 at a clock edge, set FSM to IDLE and all registered outputs to 0.
REQ-023 SHALL, on reset in WAIT, abandon the request: DReq_o=0 from the first cycle after the reset edge while ValidM_i=0; any late DAck_i is ignored.

Structure
REQ-024 SHALL take Funct3 load/store encodings, ResultSrc encodings and the IDLE/WAIT enum from shared package rv_mem_pkg.
REQ-025 SHALL place lane select and sign/zero extension in sub-module load_align (combinational: addr[1:0], Funct3, DRData_i -> 32-bit data).

Verification
REQ-026 SHALL cover LB at 0x103, DRData_i=0x80FF_1234, zero-wait ack -> next cycle ReadDataW_o=0xFFFF_FF80, RegWriteW_o=1, StallM_o never high.
REQ-027 SHALL cover SH at 0x202, data 0x0000_BEEF, ack after 3 cycles -> DBe_o=1100, DWData_o=0xBEEF_BEEF, DAddr_o=0x200, StallM_o high 3 cycles, 3 bubbles into W.
REQ-028 SHALL cover LW at 0x105 -> DReq_o stays 0, next cycle ExcW_o=1, RegWriteW_o=0.
REQ-029 SHALL cover LHU at 0x300 with DAck_i=1, DErr_i=1 -> ExcW_o=1, RegWriteW_o=0, FSM IDLE.
REQ-030 SHALL cover rst_ni=0 during WAIT, then DAck_i=1 after release with ValidM_i=0 -> all outputs 0, no W write, FSM IDLE.
